// File: rtl/cell_board_store_pkg.sv
// Shared constants for the life-board cell store: address width, mode encoding,
// FSM state encodings and B3/S23 rule thresholds.
package cell_board_store_pkg;

    localparam int unsigned ADDR_WIDTH = 8;

    localparam logic MODE_EDIT = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_SWAP = 2'd2;

    localparam logic [3:0] BIRTH_CNT  = 4'd3;
    localparam logic [3:0] SURVIVE_LO = 4'd2;
    localparam logic [3:0] SURVIVE_HI = 4'd3;

endpackage

// File: rtl/cell_board_store_life_next_state.sv
// Combinational B3/S23 rule: counts the 8 neighbour bits and decides whether
// the centre cell is alive in the next generation.
module life_next_state
    import cell_board_store_pkg::*;
(
    input  logic [7:0] nbr_i,
    input  logic       centre_i,
    output logic [3:0] count_o,
    output logic       next_o
);

    always_comb begin
        count_o = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            count_o = count_o + {3'b000, nbr_i[k]};
        end
        next_o = (count_o == BIRTH_CNT) ||
                 (centre_i && (count_o >= SURVIVE_LO) && (count_o <= SURVIVE_HI));
    end

endmodule

// File: rtl/cell_board_store.sv
// Double-banked life board with cursor edits and a one-cell-per-clock generation
// step. Define TORUS_WRAP_EN to wrap neighbour lookups around the board edges.
module cell_board_store
    import cell_board_store_pkg::*;
#(
    parameter int unsigned MAP_WIDTH  = 8,
    parameter int unsigned MAP_HEIGHT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] cell_x,
    input  logic [ADDR_WIDTH-1:0] cell_y,
    output logic                  cell_state,
    input  logic [ADDR_WIDTH-1:0] cur_x,
    input  logic [ADDR_WIDTH-1:0] cur_y,
    input  logic                  edit_toggle,
    input  logic                  edit_clear,
    input  logic                  step_req,
    output logic                  busy,
    output logic                  step_done,
    output logic [15:0]           gen_count,
    output logic [15:0]           population
);

    localparam int unsigned CELLS = MAP_WIDTH * MAP_HEIGHT;
    localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [ADDR_WIDTH:0] W_L = (ADDR_WIDTH + 1)'(MAP_WIDTH);
    localparam logic [ADDR_WIDTH:0] H_L = (ADDR_WIDTH + 1)'(MAP_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] LAST_X = ADDR_WIDTH'(MAP_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_Y = ADDR_WIDTH'(MAP_HEIGHT - 1);

    logic [CELLS-1:0]      bank0_q, bank0_d, bank1_q, bank1_d;
    logic                  front_sel_q, front_sel_d;
    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] scan_x_q, scan_x_d, scan_y_q, scan_y_d;
    logic [15:0]           acc_q, acc_d;
    logic [15:0]           pop_q, pop_d;
    logic [15:0]           gen_q, gen_d;
    logic                  busy_q, step_done_q, step_done_d;

    logic [CELLS-1:0] front, back, front_d, back_d;
    logic [8:0]       win;
    logic [3:0]       nbr_count;
    logic             next_bit;
    logic [IDX_W-1:0] rd_idx, cur_idx, scan_idx;
    logic             rd_in_range, cur_in_range;

    function automatic logic cell_at(input logic [CELLS-1:0] bank, input int xi, input int yi);
        int x;
        int y;
        x = xi;
        y = yi;
`ifdef TORUS_WRAP_EN
        if (x < 0) x = x + int'(MAP_WIDTH);
        if (x >= int'(MAP_WIDTH)) x = x - int'(MAP_WIDTH);
        if (y < 0) y = y + int'(MAP_HEIGHT);
        if (y >= int'(MAP_HEIGHT)) y = y - int'(MAP_HEIGHT);
`else
        if (x < 0 || y < 0 || x >= int'(MAP_WIDTH) || y >= int'(MAP_HEIGHT)) return 1'b0;
`endif
        return bank[IDX_W'(y * int'(MAP_WIDTH) + x)];
    endfunction

    always_comb begin
        front = front_sel_q ? bank1_q : bank0_q;
        back  = front_sel_q ? bank0_q : bank1_q;

        rd_in_range  = ({1'b0, cell_x} < W_L) && ({1'b0, cell_y} < H_L);
        rd_idx       = IDX_W'(int'(cell_y) * int'(MAP_WIDTH) + int'(cell_x));
        cell_state   = rd_in_range ? front[rd_idx] : 1'b0;

        cur_in_range = ({1'b0, cur_x} < W_L) && ({1'b0, cur_y} < H_L);
        cur_idx      = IDX_W'(int'(cur_y) * int'(MAP_WIDTH) + int'(cur_x));
        scan_idx     = IDX_W'(int'(scan_y_q) * int'(MAP_WIDTH) + int'(scan_x_q));

        // 3x3 window around the scan position; win[4] is the centre cell
        for (int unsigned k = 0; k < 9; k++) begin
            win[k] = cell_at(front,
                             int'(scan_x_q) + int'(k % 3) - 1,
                             int'(scan_y_q) + int'(k / 3) - 1);
        end
    end

    life_next_state u_rule (
        .nbr_i    ({win[8:5], win[3:0]}),
        .centre_i (win[4]),
        .count_o  (nbr_count),
        .next_o   (next_bit)
    );

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        scan_x_d    = scan_x_q;
        scan_y_d    = scan_y_q;
        acc_d       = acc_q;
        pop_d       = pop_q;
        gen_d       = gen_q;
        step_done_d = 1'b0;
        front_d     = front;
        back_d      = back;

        case (state_q)
            ST_IDLE: begin
                if (mode == MODE_EDIT) begin
                    if (edit_clear) begin
                        front_d = '0;
                        pop_d   = '0;
                        gen_d   = '0;
                    end else if (edit_toggle && cur_in_range) begin
                        front_d[cur_idx] = ~front[cur_idx];
                        pop_d = front[cur_idx] ? pop_q - 16'd1 : pop_q + 16'd1;
                    end
                end else if (step_req) begin
                    state_d  = ST_SCAN;
                    scan_x_d = '0;
                    scan_y_d = '0;
                    acc_d    = '0;
                end
            end
            ST_SCAN: begin
                back_d[scan_idx] = next_bit;
                if (next_bit) acc_d = acc_q + 16'd1;
                if (scan_x_q == LAST_X) begin
                    scan_x_d = '0;
                    if (scan_y_q == LAST_Y) state_d = ST_SWAP;
                    else                    scan_y_d = scan_y_q + 1'b1;
                end else begin
                    scan_x_d = scan_x_q + 1'b1;
                end
            end
            ST_SWAP: begin
                front_sel_d = ~front_sel_q;
                pop_d       = acc_q;
                gen_d       = gen_q + 16'd1;
                step_done_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Map front/back views back onto physical banks using the current select
        bank0_d = front_sel_q ? back_d : front_d;
        bank1_d = front_sel_q ? front_d : back_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank0_q     <= '0;
            bank1_q     <= '0;
            front_sel_q <= 1'b0;
            state_q     <= ST_IDLE;
            scan_x_q    <= '0;
            scan_y_q    <= '0;
            acc_q       <= '0;
            pop_q       <= '0;
            gen_q       <= '0;
            busy_q      <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            bank0_q     <= bank0_d;
            bank1_q     <= bank1_d;
            front_sel_q <= front_sel_d;
            state_q     <= state_d;
            scan_x_q    <= scan_x_d;
            scan_y_q    <= scan_y_d;
            acc_q       <= acc_d;
            pop_q       <= pop_d;
            gen_q       <= gen_d;
            busy_q      <= (state_d != ST_IDLE);
            step_done_q <= step_done_d;
        end
    end

    assign busy       = busy_q;
    assign step_done  = step_done_q;
    assign gen_count  = gen_q;
    assign population = pop_q;

endmodule

// File: tb/tb_cell_board_store.sv
// Directed bench for cell_board_store: read-table checks plus hand-written
// multi-cycle sequences for steps, busy drops, edit guards and mid-scan reset.
`timescale 1ns/1ps
module tb_cell_board_store;
    import cell_board_store_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = MODE_EDIT;
    logic [7:0] cell_x = '0, cell_y = '0, cur_x = '0, cur_y = '0;
    logic       edit_toggle = 1'b0, edit_clear = 1'b0, step_req = 1'b0;
    logic       cell_state, busy, step_done;
    logic [15:0] gen_count, population;

    int n_cmp = 0;
    int n_err = 0;

    cell_board_store #(.MAP_WIDTH(8), .MAP_HEIGHT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .cell_x      (cell_x),
        .cell_y      (cell_y),
        .cell_state  (cell_state),
        .cur_x       (cur_x),
        .cur_y       (cur_y),
        .edit_toggle (edit_toggle),
        .edit_clear  (edit_clear),
        .step_req    (step_req),
        .busy        (busy),
        .step_done   (step_done),
        .gen_count   (gen_count),
        .population  (population)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         grp;
        logic [7:0] x;
        logic [7:0] y;
        logic       exp;
    } rd_vec_t;

    rd_vec_t tab[24];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_group(input int g, input string tag);
        for (int i = 0; i < 24; i++) begin
            if (tab[i].grp == g) begin
                cell_x = tab[i].x;
                cell_y = tab[i].y;
                #0.1;
                check($sformatf("%s rd(%0d,%0d)", tag, tab[i].x, tab[i].y),
                      int'(cell_state), int'(tab[i].exp));
            end
        end
    endtask

    task automatic toggle_at(input logic [7:0] x, input logic [7:0] y);
        cur_x = x;
        cur_y = y;
        edit_toggle = 1'b1;
        tick();
        edit_toggle = 1'b0;
    endtask

    task automatic clear_board();
        mode = MODE_EDIT;
        edit_clear = 1'b1;
        tick();
        edit_clear = 1'b0;
    endtask

    // Pulse step_req and watch 80 edges; probe (cell_x,cell_y) must hold through the scan
    task automatic do_step(input bit second_req, output int busy_n, output int done_n,
                           output int done_at, output int unstable);
        logic ref_bit;
        ref_bit  = cell_state;
        busy_n   = 0;
        done_n   = 0;
        done_at  = -1;
        unstable = 0;
        mode     = ~MODE_EDIT;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        if (busy) busy_n++;
        if (step_done) done_n++;
        for (int i = 1; i <= 80; i++) begin
            if (second_req && i == 10) step_req = 1'b1;
            tick();
            step_req = 1'b0;
            if (busy) busy_n++;
            if (step_done) begin
                done_n++;
                done_at = i;
            end
            if (i <= 64 && cell_state != ref_bit) unstable++;
        end
    endtask

    int  busy_n, done_n, done_at, unstable;
    logic corner_exp;

    initial begin
`ifdef TORUS_WRAP_EN
        corner_exp = 1'b1;
`else
        corner_exp = 1'b0;
`endif
        tab[0]  = '{0, 8'd3, 8'd2, 1'b1};
        tab[1]  = '{0, 8'd3, 8'd3, 1'b1};
        tab[2]  = '{0, 8'd3, 8'd4, 1'b1};
        tab[3]  = '{0, 8'd2, 8'd3, 1'b0};
        tab[4]  = '{0, 8'd4, 8'd3, 1'b0};
        tab[5]  = '{1, 8'd2, 8'd3, 1'b1};
        tab[6]  = '{1, 8'd3, 8'd3, 1'b1};
        tab[7]  = '{1, 8'd4, 8'd3, 1'b1};
        tab[8]  = '{1, 8'd3, 8'd2, 1'b0};
        tab[9]  = '{1, 8'd3, 8'd4, 1'b0};
        tab[10] = '{2, 8'd0, 8'd0, 1'b1};
        tab[11] = '{2, 8'd0, 8'd1, 1'b1};
        tab[12] = '{2, 8'd8, 8'd0, 1'b0};
        tab[13] = '{2, 8'd255, 8'd255, 1'b0};
        tab[14] = '{2, 8'd0, 8'd8, 1'b0};
        tab[15] = '{3, 8'd0, 8'd0, 1'b0};
        tab[16] = '{3, 8'd3, 8'd3, 1'b0};
        tab[17] = '{3, 8'd7, 8'd7, 1'b0};
        tab[18] = '{3, 8'd3, 8'd2, 1'b0};
        tab[19] = '{4, 8'd0, 8'd0, corner_exp};
        tab[20] = '{4, 8'd7, 8'd0, corner_exp};
        tab[21] = '{4, 8'd0, 8'd7, corner_exp};
        tab[22] = '{4, 8'd7, 8'd7, corner_exp};
        tab[23] = '{9, 8'd0, 8'd0, 1'b0};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset busy", int'(busy), 0);
        check("reset step_done", int'(step_done), 0);
        check("reset gen_count", int'(gen_count), 0);
        check("reset population", int'(population), 0);
        check_group(3, "reset");

        // Vertical blinker via edits
        mode = MODE_EDIT;
        toggle_at(8'd3, 8'd2);
        toggle_at(8'd3, 8'd3);
        toggle_at(8'd3, 8'd4);
        check("blinker population", int'(population), 3);
        check_group(0, "vertical");

        // Edit guards: off-map cursor and run-mode toggle
        toggle_at(8'd8, 8'd0);
        check("offmap toggle population", int'(population), 3);
        cell_x = 8'd0; cell_y = 8'd1; #0.1;
        check("offmap toggle alias cell", int'(cell_state), 0);
        mode = ~MODE_EDIT;
        toggle_at(8'd0, 8'd0);
        cell_x = 8'd0; cell_y = 8'd0; #0.1;
        check("run-mode toggle cell", int'(cell_state), 0);
        check("run-mode toggle population", int'(population), 3);
        mode = MODE_EDIT;
        cur_x = 8'd0; cur_y = 8'd0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("edit-mode step_req busy", int'(busy), 0);

        // First step, with a second step_req dropped at cycle 10
        cell_x = 8'd3; cell_y = 8'd2; #0.1;
        do_step(1'b1, busy_n, done_n, done_at, unstable);
        check("step1 busy cycles", busy_n, 65);
        check("step1 done count", done_n, 1);
        check("step1 done edge", done_at, 65);
        check("step1 front stable", unstable, 0);
        check("step1 gen_count", int'(gen_count), 1);
        check("step1 population", int'(population), 3);
        check_group(1, "horizontal");

        // Second step restores the vertical bar
        cell_x = 8'd3; cell_y = 8'd3; #0.1;
        do_step(1'b0, busy_n, done_n, done_at, unstable);
        check("step2 done count", done_n, 1);
        check("step2 gen_count", int'(gen_count), 2);
        check("step2 population", int'(population), 3);
        check_group(0, "vertical2");

        // Simultaneous clear and toggle: clear wins
        mode = MODE_EDIT;
        cur_x = 8'd5; cur_y = 8'd5;
        edit_clear = 1'b1;
        edit_toggle = 1'b1;
        tick();
        edit_clear = 1'b0;
        edit_toggle = 1'b0;
        check("clear population", int'(population), 0);
        check("clear gen_count", int'(gen_count), 0);
        check_group(3, "cleared");
        cell_x = 8'd5; cell_y = 8'd5; #0.1;
        check("clear beats toggle", int'(cell_state), 0);

        // Read bounds with (0,0) and (0,1) live
        toggle_at(8'd0, 8'd0);
        toggle_at(8'd0, 8'd1);
        check_group(2, "bounds");
        toggle_at(8'd0, 8'd1);
        check("toggle-off population", int'(population), 1);

        // Corner block
        clear_board();
        toggle_at(8'd0, 8'd0);
        toggle_at(8'd7, 8'd0);
        toggle_at(8'd0, 8'd7);
        toggle_at(8'd7, 8'd7);
        check("corner population pre", int'(population), 4);
        do_step(1'b0, busy_n, done_n, done_at, unstable);
        check("corner done count", done_n, 1);
        check("corner population", int'(population), corner_exp ? 4 : 0);
        check("corner gen_count", int'(gen_count), 1);
        check_group(4, "corner");

        // Reset during scan aborts the step
        clear_board();
        toggle_at(8'd3, 8'd3);
        toggle_at(8'd4, 8'd3);
        mode = ~MODE_EDIT;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        for (int i = 1; i < 20; i++) tick();
        check("mid-scan busy", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort gen_count", int'(gen_count), 0);
        check("abort population", int'(population), 0);
        check_group(3, "abort");
        done_n = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (step_done) done_n++;
        end
        check("abort step_done seen", done_n, 0);
        check("abort gen_count late", int'(gen_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
